alu_sched: RTL
==============

# alu_sched

Two-requester scheduler that shares the single 4-bit combinational ALU between independent clients. It accepts operations over valid/ready request ports, arbitrates round-robin, and drives the ALU A/B/SEL inputs from registered operands. It captures RESULT/CARRY after one settle cycle and returns them with the requester ID on a backpressured response port. It sits between client logic and the ALU; the ALU itself is instantiated alongside it, unmodified.

## Interface
- DATA_W, 4, operand/result width; must match the ALU.
- SEL_W, 3, opcode width; must match the ALU SEL.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester has an operation pending.
- req0_ready / req1_ready  out  1  operation accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands.
- req0_sel / req1_sel  in  SEL_W  ALU opcode, passed through opaque.
- alu_a, alu_b  out  DATA_W  registered ALU operands.
- alu_sel  out  SEL_W  registered ALU opcode.
- alu_result  in  DATA_W  ALU RESULT.
- alu_carry  in  1  ALU CARRY.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  DATA_W  captured result.
- rsp_carry  out  1  captured carry.
- rsp_id  out  1  requester that issued the op (0/1).
- busy  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any reqN_valid, the arbiter grants one requester. Only the granted reqN_ready is asserted, for that cycle only. Its a/b/sel load into alu_a/alu_b/alu_sel and its ID into an ID register. Next state is EXEC.
- EXEC: lasts one cycle; alu_* stay stable. At the end of the cycle alu_result/alu_carry/ID load into rsp_*. Next state is RESP.
- RESP: rsp_valid=1; rsp_* and alu_* hold until rsp_ready.
  - rsp_ready with no pending valid → IDLE.
  - rsp_ready with a pending valid → arbitrate and accept in the same cycle → EXEC (back-to-back path).
- Arbitration: round-robin with a 1-bit pointer to the preferred requester. A lone valid always wins. If both are valid, the pointer wins. On every grant, the pointer moves to the non-granted requester.
- reqN_ready = accept_slot & grantN, where accept_slot = IDLE | (RESP & rsp_ready).
- Requesters hold valid and operands stable until ready; the block never drops an accepted op.
- Arithmetic: none internal; ALU width rules apply; SEL values are not decoded.

## Timing
- Reset (async, immediate): state IDLE, pointer=0, all outputs 0 (ready, alu_*, rsp_*, busy).
- Latency: from req accept edge to rsp_valid high is 2 cycles.
- Throughput: with rsp_ready held high, one op per 2 cycles.
- reqN_ready is combinational from valid, state, pointer and rsp_ready. rsp_valid and alu_* are registered.
- Simultaneous events:
  - Both valid in the same slot → the pointer side is granted and the other waits.
  - rsp_ready and a new valid in RESP → response retired and new op accepted on the same edge.
- rsp_ready while not in RESP is ignored.
- Reset mid-EXEC/RESP: the in-flight op is discarded and no response is produced. The requester is not re-notified.

## Structure
- Package alu_sched_pkg holds:
  - the state enum (IDLE/EXEC/RESP);
  - DATA_W/SEL_W defaults;
  - opcode localparams for benches: SEL_ADD=3'b000, SEL_SUB=3'b001, SEL_AND=3'b010, SEL_OR=3'b011, SEL_XOR=3'b100, SEL_SHL=3'b101, SEL_SHR=3'b110, SEL_NOT=3'b111.
- Sub-module rr_arb2 contains the 2-way round-robin arbiter. Its inputs are the two valids, the accept_slot enable, clk and rst_n. Its outputs are a one-hot grant and the registered pointer.
- The bench instantiates alu_sched and the real ALU together.

## Test plan
- Reset: assert rst_n=0 mid-RESP → rsp_valid, busy and alu_* go to 0 immediately. Next op after release is granted to req0 (pointer=0).
- Single op: req0 A=0011 B=0101 SEL=000 → req0_ready for 1 cycle. 2 cycles later rsp_valid=1, rsp_result=1000, rsp_carry=0, rsp_id=0.
- Contention: both valid constantly, rsp_ready=1:
  - req0 issues A=1100 B=1010 SEL=010; req1 issues A=1100 B=1010 SEL=011.
  - Grants alternate 0,1,0,1; responses 1000 (id0) and 1110 (id1) repeat.
  - Each response arrives 2 cycles after its grant.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_* and alu_* stable and no reqN_ready. Release → the pending op is accepted on the same edge.
- Carry path: req1 A=1001 B=1001 SEL=000 → rsp_result=0010, rsp_carry=1, rsp_id=1.
- Idle behaviour: no valids for 10 cycles → busy=0, readys 0, pointer unchanged.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
// The opcode constants describe the attached ALU; the scheduler never decodes them.
package alu_sched_pkg;

  localparam int DATA_W = 4;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_SUB = 3'b001;
  localparam logic [2:0] SEL_AND = 3'b010;
  localparam logic [2:0] SEL_OR  = 3'b011;
  localparam logic [2:0] SEL_XOR = 3'b100;
  localparam logic [2:0] SEL_SHL = 3'b101;
  localparam logic [2:0] SEL_SHR = 3'b110;
  localparam logic [2:0] SEL_NOT = 3'b111;

endpackage

// File: rtl/alu.sv
// Shared 4-bit combinational ALU. CARRY is carry-out for ADD, borrow for SUB,
// and the bit shifted out for SHL/SHR; it is zero for the logic operations.
module alu #(
  parameter int DATA_W = 4,
  parameter int SEL_W  = 3
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] result,
  output logic              carry
);
  import alu_sched_pkg::*;

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (sel)
      SEL_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
      SEL_SUB: {carry, result} = {1'b0, a} - {1'b0, b};
      SEL_AND: result = a & b;
      SEL_OR:  result = a | b;
      SEL_XOR: result = a ^ b;
      SEL_SHL: {carry, result} = {a, 1'b0};
      SEL_SHR: {result, carry} = {1'b0, a};
      SEL_NOT: result = ~a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone valid always wins, a tie goes to the
// pointer side, and every grant hands priority to the other requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant,
  output logic       ptr
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  // grant[0] set means requester 0 won, so requester 1 becomes preferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (en && (|valid)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one combinational ALU between two requesters: accept, hold operands
// for a settle cycle, capture the result, then present it until consumed.
module alu_sched #(
  parameter int DATA_W = alu_sched_pkg::DATA_W,
  parameter int SEL_W  = alu_sched_pkg::SEL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_W-1:0]     req0_a,
  input  logic [DATA_W-1:0]     req0_b,
  input  logic [SEL_W-1:0]      req0_sel,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_W-1:0]     req1_a,
  input  logic [DATA_W-1:0]     req1_b,
  input  logic [SEL_W-1:0]      req1_sel,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [SEL_W-1:0]      alu_sel,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_carry,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_result,
  output logic                  rsp_carry,
  output logic                  rsp_id,
  output logic                  busy,
  output alu_sched_pkg::state_e dbg_state,
  output logic                  dbg_ptr
);
  import alu_sched_pkg::*;

  // Handshake: a request transfers on a rising edge where reqN_valid and
  // reqN_ready are both high; a response transfers where rsp_valid and
  // rsp_ready are both high. Requesters hold valid and operands until ready.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0] state;
  logic [1:0] grant;
  logic       ptr;
  logic       accept_slot;
  logic       accept;
  logic       id_q;

  // Reset gating keeps both readys low while rst_n is asserted.
  assign accept_slot = rst_n & ((state == ST_IDLE) | ((state == ST_RESP) & rsp_ready));

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid ({req1_valid, req0_valid}),
    .en    (accept_slot),
    .grant (grant),
    .ptr   (ptr)
  );

  assign req0_ready = accept_slot & grant[0];
  assign req1_ready = accept_slot & grant[1];
  assign accept     = req0_ready | req1_ready;
  assign busy       = (state != ST_IDLE);
  assign dbg_state  = state_e'(state);
  assign dbg_ptr    = ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_id     <= 1'b0;
    end else begin
      if (accept) begin
        alu_a   <= grant[1] ? req1_a   : req0_a;
        alu_b   <= grant[1] ? req1_b   : req0_b;
        alu_sel <= grant[1] ? req1_sel : req0_sel;
        id_q    <= grant[1];
      end
      case (state)
        ST_IDLE: if (accept) state <= ST_EXEC;
        ST_EXEC: begin
          rsp_result <= alu_result;
          rsp_carry  <= alu_carry;
          rsp_id     <= id_q;
          rsp_valid  <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= accept ? ST_EXEC : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
